// File: rtl/wallace_cpa_seq.sv
// wallace_cpa_seq: chunked sequential carry-propagate adder for the Wallace tree's sum/carry rows.
// Adds CHUNK bits per clock through a registered ripple carry; valid/ready on both sides.
// Optional WALLACE_CPA_B2B_EN: accept the next row pair in the same cycle a result is taken.
module wallace_cpa_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_result
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] op_a, op_b;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_co;
    logic             accept;
    logic             last;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state and handshake outputs; accepting in DONE only happens in back-to-back mode
    always_comb begin
`ifdef WALLACE_CPA_B2B_EN
        in_ready = state == IDLE || (state == DONE && out_ready);
`else
        in_ready = state == IDLE;
`endif
        out_valid  = state == DONE;
        accept     = in_valid && in_ready;
        last       = idx == IW'(NCHUNK - 1);
        next_state = state;
        case (state)
            IDLE:    next_state = accept ? BUSY : IDLE;
            BUSY:    next_state = last ? DONE : BUSY;
            DONE:    next_state = out_ready ? (accept ? BUSY : IDLE) : DONE;
            default: next_state = IDLE;
        endcase
    end

    // One CHUNK-wide full-adder ripple over the current chunk, seeded by the registered carry
    always_comb begin
        logic c;
        c         = carry;
        chunk_sum = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_sum[i] = op_a[int'(idx) * CHUNK + i] ^ op_b[int'(idx) * CHUNK + i] ^ c;
            c = (op_a[int'(idx) * CHUNK + i] & op_b[int'(idx) * CHUNK + i]) |
                (c & (op_a[int'(idx) * CHUNK + i] ^ op_b[int'(idx) * CHUNK + i]));
        end
        chunk_co = c;
    end

    // Operand capture, per-chunk result write-back and carry/index advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            carry      <= 1'b0;
            idx        <= '0;
            out_result <= '0;
        end else if (accept) begin
            op_a  <= in_sum;
            op_b  <= in_carry;
            carry <= in_cin;
            idx   <= '0;
        end else if (state == BUSY) begin
            out_result[int'(idx) * CHUNK +: CHUNK] <= chunk_sum;
            carry <= chunk_co;
            idx   <= last ? '0 : idx + IW'(1);
            if (last) out_result[WIDTH] <= chunk_co;
        end
    end
endmodule

// File: doc/wallace_cpa_seq.md
Name: wallace_cpa_seq

Overview:
- Final carry-propagate adder stage that sits directly downstream of the Wallace compression tree.
- Consumes the two residual rows (sum row and carry row, already weight-aligned) left after full-adder compression. Produces the binary product word.
- Sequential: adds CHUNK bits per clock with a registered ripple carry, trading latency for a short critical path. Valid/ready handshake on both sides.

Parameters:
- WIDTH, 16, bit width of each input row; must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per clock cycle; NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream row pair valid.
- in_ready  output  1  block can accept a row pair.
- in_sum  input  WIDTH  sum row from the compression tree.
- in_carry  input  WIDTH  carry row from the compression tree, pre-shifted to align with in_sum.
- in_cin  input  1  carry-in at bit 0.
- out_valid  output  1  out_result holds a completed sum.
- out_ready  input  1  downstream accepts the result.
- out_result  output  WIDTH+1  in_sum + in_carry + in_cin; MSB is the final carry.

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; out_result=0; operand registers, chunk index and carry register all 0. Reset is async and may assert in any state; it aborts any operation in flight, and no partial result is presented.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid: capture in_sum, in_carry, in_cin; idx=0; carry register=in_cin; go to BUSY.
  - BUSY: in_ready=0, out_valid=0. Each edge computes chunk idx with a CHUNK-bit ripple using the full-adder equations (s = a^b^c, co = a&b | c&(a^b)). The chunk result goes to out_result[idx*CHUNK +: CHUNK], the chunk carry-out goes to the carry register, and idx is incremented. On the edge processing idx=NCHUNK-1: out_result[WIDTH] = final carry; go to DONE.
  - DONE: out_valid=1, in_ready=0. out_result is held stable while out_valid=1 and out_ready=0. On out_ready: out_valid falls and the FSM returns to IDLE.
- Latency:
  - out_valid rises exactly NCHUNK cycles after the accepting edge (4 cycles for the defaults).
  - Without the optional feature, throughput is one result per NCHUNK+2 cycles.
- Boundary conditions:
  - in_valid while BUSY or DONE is ignored; upstream holds its data because in_ready=0.
  - out_ready while IDLE or BUSY has no effect.
  - All-ones rows with cin=1 produce 2^(WIDTH+1)-1; the carry ripples across every chunk boundary.
  - CHUNK=WIDTH degenerates to a single BUSY cycle.
- Arithmetic is unsigned modulo 2^(WIDTH+1); no overflow can occur.
- out_result bits not yet written during BUSY are don't-care; the bench checks out_result only while out_valid=1.

Optional Feature:
- Macro: WALLACE_CPA_B2B_EN.
- Defined:
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
  - A DONE-state handshake together with in_valid goes directly to BUSY with new operands captured.
  - Gives back-to-back throughput of one result per NCHUNK+1 cycles.
- Undefined: in_ready is high only in IDLE, and a one-cycle IDLE bubble always follows DONE.

Test Plan:
- in_sum=0x1234, in_carry=0x4321, cin=0, out_ready=1 -> out_valid high 4 cycles after accept; out_result=0x05555.
- in_sum=0xFFFF, in_carry=0x0001, cin=0 -> out_result=0x10000 (carry crosses all chunks).
- in_sum=0xFFFF, in_carry=0xFFFF, cin=1 -> out_result=0x1FFFF.
- Backpressure: complete 0x00FF+0x0F00, hold out_ready=0 for 10 cycles -> out_valid stays 1, out_result=0x00FFF stable, in_ready=0 throughout; release -> IDLE the next cycle.
- Reset mid-op: assert rst_n=0 during the second BUSY cycle -> outputs immediately at reset values; after release, a fresh 0x0003+0x0005 yields 0x00008.
- WALLACE_CPA_B2B_EN: two operand pairs streamed with out_ready=1 and in_valid held -> the second accept coincides with the first result handshake; results arrive 5 cycles apart. Without the macro they arrive 6 apart.
